// File: rtl/siu_dmu_pkt_rcv_if.sv
// SIU-to-DMU packet receive bundle: SIU header/payload stream in, buffered packets out.
// The slave side is the receiver; the master side is whoever drives the SIU stream and consumes packets.
interface siu_dmu_pkt_rcv_if;
    logic         sio_dmu_hdr_vld;
    logic         sio_dmu_datareq;
    logic [127:0] sio_dmu_data;
    logic [7:0]   sio_dmu_parity;

    // Output handshake: the head entry is held on pkt_* while pkt_vld is high.
    // It is consumed on any rising edge with pkt_vld & pkt_rdy.
    // pkt_rdy has no effect while pkt_vld is low.
    logic         pkt_vld;
    logic         pkt_rdy;
    logic [127:0] pkt_hdr;
    logic         pkt_has_data;
    logic [511:0] pkt_data;
    logic         pkt_par_err;

    logic         ovf_err;
    logic         proto_err;
    logic [7:0]   drop_cnt;

    logic         dbg_state;
    logic [1:0]   dbg_beat;

    modport slave (
        input  sio_dmu_hdr_vld, sio_dmu_datareq, sio_dmu_data, sio_dmu_parity, pkt_rdy,
        output pkt_vld, pkt_hdr, pkt_has_data, pkt_data, pkt_par_err,
        output ovf_err, proto_err, drop_cnt, dbg_state, dbg_beat
    );

    modport master (
        output sio_dmu_hdr_vld, sio_dmu_datareq, sio_dmu_data, sio_dmu_parity, pkt_rdy,
        input  pkt_vld, pkt_hdr, pkt_has_data, pkt_data, pkt_par_err,
        input  ovf_err, proto_err, drop_cnt, dbg_state, dbg_beat
    );
endinterface

// File: rtl/siu_dmu_pkt_rcv.sv
// Assembles SIU header(+4 payload beats) packets, checks lane parity, and queues completed
// packets in a small FIFO presented on pkt_*; drops are counted and flagged stickily.
module siu_dmu_pkt_rcv #(
    parameter int BUF_DEPTH = 2
) (
    input logic               iol2clk,
    input logic               rst,
    siu_dmu_pkt_rcv_if.slave  bus
);
    localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic {ST_IDLE = 1'b0, ST_PAYLOAD = 1'b1} state_t;

    state_t       state_q, state_d;
    logic [1:0]   beat_q, beat_d;
    logic [127:0] hdr_acc_q, hdr_acc_d;
    logic [383:0] data_acc_q, data_acc_d;
    logic         par_acc_q, par_acc_d;

    logic [127:0] buf_hdr_q  [BUF_DEPTH];
    logic [127:0] buf_hdr_d  [BUF_DEPTH];
    logic [511:0] buf_data_q [BUF_DEPTH];
    logic [511:0] buf_data_d [BUF_DEPTH];
    logic         buf_has_q  [BUF_DEPTH];
    logic         buf_has_d  [BUF_DEPTH];
    logic         buf_par_q  [BUF_DEPTH];
    logic         buf_par_d  [BUF_DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d, proto_q, proto_d;
    logic [7:0]       drop_q, drop_d;

    logic [7:0]   lane_bad;
    logic         cyc_par_err;
    logic         abort;
    logic         cpl_vld, cpl_has, cpl_par;
    logic [127:0] cpl_hdr;
    logic [511:0] cpl_data;
    logic         pop, full, accept, overflow;
    logic [8:0]   drop_sum;

    always_comb begin
        lane_bad = '0;
        for (int i = 0; i < 8; i++) begin
            lane_bad[i] = (^bus.sio_dmu_data[16*i +: 16]) ^ bus.sio_dmu_parity[i];
        end
        cyc_par_err = |lane_bad;
    end

    always_ff @(posedge iol2clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            beat_q     <= '0;
            hdr_acc_q  <= '0;
            data_acc_q <= '0;
            par_acc_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            beat_q     <= beat_d;
            hdr_acc_q  <= hdr_acc_d;
            data_acc_q <= data_acc_d;
            par_acc_q  <= par_acc_d;
        end
    end

    // A header always wins: in PAYLOAD it aborts the partial packet and restarts assembly.
    always_comb begin
        state_d    = state_q;
        beat_d     = beat_q;
        hdr_acc_d  = hdr_acc_q;
        data_acc_d = data_acc_q;
        par_acc_d  = par_acc_q;
        abort      = 1'b0;
        cpl_vld    = 1'b0;
        cpl_has    = 1'b0;
        cpl_par    = 1'b0;
        cpl_hdr    = '0;
        cpl_data   = '0;
        if (bus.sio_dmu_hdr_vld) begin
            abort  = (state_q == ST_PAYLOAD);
            beat_d = '0;
            if (bus.sio_dmu_datareq) begin
                state_d   = ST_PAYLOAD;
                hdr_acc_d = bus.sio_dmu_data;
                par_acc_d = cyc_par_err;
            end else begin
                state_d = ST_IDLE;
                cpl_vld = 1'b1;
                cpl_hdr = bus.sio_dmu_data;
                cpl_par = cyc_par_err;
            end
        end else if (state_q == ST_PAYLOAD) begin
            par_acc_d = par_acc_q | cyc_par_err;
            beat_d    = beat_q + 2'd1;
            unique case (beat_q)
                2'd0: data_acc_d[127:0]   = bus.sio_dmu_data;
                2'd1: data_acc_d[255:128] = bus.sio_dmu_data;
                2'd2: data_acc_d[383:256] = bus.sio_dmu_data;
                2'd3: begin
                    state_d  = ST_IDLE;
                    cpl_vld  = 1'b1;
                    cpl_has  = 1'b1;
                    cpl_hdr  = hdr_acc_q;
                    cpl_data = {bus.sio_dmu_data, data_acc_q};
                    cpl_par  = par_acc_q | cyc_par_err;
                end
                default: ;
            endcase
        end
    end

    // A pop in the same cycle frees the slot a full-buffer completion needs.
    always_comb begin
        pop      = (cnt_q != '0) && bus.pkt_rdy;
        full     = (cnt_q == CNT_W'(BUF_DEPTH));
        accept   = cpl_vld && (!full || pop);
        overflow = cpl_vld && full && !pop;

        buf_hdr_d  = buf_hdr_q;
        buf_data_d = buf_data_q;
        buf_has_d  = buf_has_q;
        buf_par_d  = buf_par_q;
        if (accept) begin
            buf_hdr_d[wr_ptr_q]  = cpl_hdr;
            buf_data_d[wr_ptr_q] = cpl_data;
            buf_has_d[wr_ptr_q]  = cpl_has;
            buf_par_d[wr_ptr_q]  = cpl_par;
        end
        wr_ptr_d = wr_ptr_q + PTR_W'(accept);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop);
        cnt_d    = cnt_q + CNT_W'(accept) - CNT_W'(pop);

        ovf_d    = ovf_q | overflow;
        proto_d  = proto_q | abort;
        drop_sum = {1'b0, drop_q} + 9'(abort) + 9'(overflow);
        drop_d   = (drop_sum > 9'd255) ? 8'hFF : drop_sum[7:0];
    end

    always_ff @(posedge iol2clk) begin
        if (rst) begin
            for (int i = 0; i < BUF_DEPTH; i++) begin
                buf_hdr_q[i]  <= '0;
                buf_data_q[i] <= '0;
                buf_has_q[i]  <= 1'b0;
                buf_par_q[i]  <= 1'b0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            ovf_q    <= 1'b0;
            proto_q  <= 1'b0;
            drop_q   <= '0;
        end else begin
            buf_hdr_q  <= buf_hdr_d;
            buf_data_q <= buf_data_d;
            buf_has_q  <= buf_has_d;
            buf_par_q  <= buf_par_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            cnt_q      <= cnt_d;
            ovf_q      <= ovf_d;
            proto_q    <= proto_d;
            drop_q     <= drop_d;
        end
    end

    always_comb begin
        bus.pkt_vld      = (cnt_q != '0);
        bus.pkt_hdr      = bus.pkt_vld ? buf_hdr_q[rd_ptr_q]  : '0;
        bus.pkt_data     = bus.pkt_vld ? buf_data_q[rd_ptr_q] : '0;
        bus.pkt_has_data = bus.pkt_vld & buf_has_q[rd_ptr_q];
        bus.pkt_par_err  = bus.pkt_vld & buf_par_q[rd_ptr_q];
        bus.ovf_err      = ovf_q;
        bus.proto_err    = proto_q;
        bus.drop_cnt     = drop_q;
        bus.dbg_state    = state_q;
        bus.dbg_beat     = beat_q;
    end
endmodule

// File: tb/tb_siu_dmu_pkt_rcv.sv
// Directed bench for siu_dmu_pkt_rcv: a queue-level packet model checked every cycle,
// plus literal expectations at key points of each scenario.
module tb_siu_dmu_pkt_rcv;
    localparam int DEPTH = 2;

    logic iol2clk = 1'b0;
    logic rst     = 1'b1;

    siu_dmu_pkt_rcv_if bus_if ();

    siu_dmu_pkt_rcv #(.BUF_DEPTH(DEPTH)) dut (
        .iol2clk (iol2clk),
        .rst     (rst),
        .bus     (bus_if)
    );

    always #5 iol2clk = ~iol2clk;

    typedef struct {
        logic [127:0] hdr;
        logic [511:0] data;
        logic         has;
        logic         par;
    } pkt_t;

    pkt_t exp_q[$];
    pkt_t cur;
    bit   in_pkt  = 1'b0;
    int   nbeats  = 0;
    bit   m_ovf   = 1'b0;
    bit   m_proto = 1'b0;
    int   m_drops = 0;

    int total = 0;
    int bad   = 0;

    function automatic logic [7:0] good_par(input logic [127:0] d);
        logic [7:0] p;
        for (int i = 0; i < 8; i++) p[i] = ^d[16*i +: 16];
        return p;
    endfunction

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Packet-level model: reacts to the same stimulus the DUT sees on each rising edge.
    always @(posedge iol2clk) begin
        bit   done;
        bit   perr;
        pkt_t cp;
        if (rst) begin
            exp_q.delete();
            in_pkt  = 1'b0;
            nbeats  = 0;
            m_ovf   = 1'b0;
            m_proto = 1'b0;
            m_drops = 0;
        end else begin
            done = 1'b0;
            perr = (good_par(bus_if.sio_dmu_data) != bus_if.sio_dmu_parity);
            cp   = '{hdr: '0, data: '0, has: 1'b0, par: 1'b0};
            if (bus_if.sio_dmu_hdr_vld) begin
                if (in_pkt) begin
                    m_proto = 1'b1;
                    if (m_drops < 255) m_drops++;
                end
                if (bus_if.sio_dmu_datareq) begin
                    in_pkt = 1'b1;
                    nbeats = 0;
                    cur    = '{hdr: bus_if.sio_dmu_data, data: '0, has: 1'b1, par: perr};
                end else begin
                    in_pkt = 1'b0;
                    done   = 1'b1;
                    cp     = '{hdr: bus_if.sio_dmu_data, data: '0, has: 1'b0, par: perr};
                end
            end else if (in_pkt) begin
                cur.data[128*nbeats +: 128] = bus_if.sio_dmu_data;
                cur.par = cur.par | perr;
                nbeats++;
                if (nbeats == 4) begin
                    in_pkt = 1'b0;
                    done   = 1'b1;
                    cp     = cur;
                end
            end
            if (exp_q.size() > 0 && bus_if.pkt_rdy) void'(exp_q.pop_front());
            if (done) begin
                if (exp_q.size() < DEPTH) exp_q.push_back(cp);
                else begin
                    m_ovf = 1'b1;
                    if (m_drops < 255) m_drops++;
                end
            end
        end
    end

    always @(negedge iol2clk) begin
        if (!rst) begin
            check("pkt_vld", 512'(bus_if.pkt_vld), 512'(exp_q.size() > 0));
            if (exp_q.size() > 0) begin
                check("pkt_hdr", 512'(bus_if.pkt_hdr), 512'(exp_q[0].hdr));
                check("pkt_data", bus_if.pkt_data, exp_q[0].data);
                check("pkt_has_data", 512'(bus_if.pkt_has_data), 512'(exp_q[0].has));
                check("pkt_par_err", 512'(bus_if.pkt_par_err), 512'(exp_q[0].par));
            end
            check("ovf_err", 512'(bus_if.ovf_err), 512'(m_ovf));
            check("proto_err", 512'(bus_if.proto_err), 512'(m_proto));
            check("drop_cnt", 512'(bus_if.drop_cnt), 512'(m_drops));
        end
    end

    // One sampling edge per call; returns 1 time unit after that edge.
    task automatic step(input logic hv, input logic dr, input logic [127:0] d,
                        input logic [7:0] flip, input logic rdy);
        bus_if.sio_dmu_hdr_vld = hv;
        bus_if.sio_dmu_datareq = dr;
        bus_if.sio_dmu_data    = d;
        bus_if.sio_dmu_parity  = good_par(d) ^ flip;
        bus_if.pkt_rdy         = rdy;
        @(posedge iol2clk);
        #1;
    endtask

    task automatic idle(input logic rdy, input int n);
        for (int i = 0; i < n; i++)
            step(1'b0, 1'($urandom_range(0, 1)), {$urandom, $urandom, $urandom, $urandom}, 8'h00, rdy);
    endtask

    task automatic beat(input logic [127:0] d, input logic [7:0] flip, input logic rdy);
        step(1'b0, 1'($urandom_range(0, 1)), d, flip, rdy);
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_vld"}, 512'(bus_if.pkt_vld), '0);
        check({tag, "_hdr"}, 512'(bus_if.pkt_hdr), '0);
        check({tag, "_data"}, bus_if.pkt_data, '0);
        check({tag, "_has"}, 512'(bus_if.pkt_has_data), '0);
        check({tag, "_par"}, 512'(bus_if.pkt_par_err), '0);
        check({tag, "_ovf"}, 512'(bus_if.ovf_err), '0);
        check({tag, "_proto"}, 512'(bus_if.proto_err), '0);
        check({tag, "_drop"}, 512'(bus_if.drop_cnt), '0);
    endtask

    localparam logic [127:0] HDR_A5 = 128'h0123_4567_89ab_cdef_0000_0000_0000_00a5;
    localparam logic [127:0] BT0 = {16{8'h11}};
    localparam logic [127:0] BT1 = {16{8'h22}};
    localparam logic [127:0] BT2 = {16{8'h33}};
    localparam logic [127:0] BT3 = {16{8'h44}};

    initial begin
        rst = 1'b1;
        idle(1'b0, 3);
        check_zero_outputs("reset");
        rst = 1'b0;

        // Header-only packet, popped on the cycle it becomes visible.
        step(1'b1, 1'b0, HDR_A5, 8'h00, 1'b1);
        check("hdronly_vld", 512'(bus_if.pkt_vld), 512'd1);
        check("hdronly_hdr", 512'(bus_if.pkt_hdr), 512'(HDR_A5));
        check("hdronly_has", 512'(bus_if.pkt_has_data), 512'd0);
        check("hdronly_data", bus_if.pkt_data, '0);
        idle(1'b1, 1);
        check("hdronly_popped", 512'(bus_if.pkt_vld), 512'd0);

        // Four-beat payload packet.
        step(1'b1, 1'b1, 128'hdead_0001, 8'h00, 1'b0);
        beat(BT0, 8'h00, 1'b0);
        beat(BT1, 8'h00, 1'b0);
        beat(BT2, 8'h00, 1'b0);
        check("pay_not_yet", 512'(bus_if.pkt_vld), 512'd0);
        beat(BT3, 8'h00, 1'b0);
        check("pay_vld", 512'(bus_if.pkt_vld), 512'd1);
        check("pay_hdr", 512'(bus_if.pkt_hdr), 512'h dead_0001);
        check("pay_beat0", 512'(bus_if.pkt_data[127:0]), 512'(BT0));
        check("pay_beat3", 512'(bus_if.pkt_data[511:384]), 512'(BT3));
        check("pay_all", bus_if.pkt_data, {BT3, BT2, BT1, BT0});
        check("pay_has", 512'(bus_if.pkt_has_data), 512'd1);
        check("pay_par", 512'(bus_if.pkt_par_err), 512'd0);
        idle(1'b1, 1);

        // Parity error on beat 2 lane 5, then a clean packet.
        step(1'b1, 1'b1, 128'hdead_0002, 8'h00, 1'b0);
        beat(BT0, 8'h00, 1'b0);
        beat(BT1, 8'h00, 1'b0);
        beat(BT2, 8'h20, 1'b0);
        beat(BT3, 8'h00, 1'b0);
        check("perr_vld", 512'(bus_if.pkt_vld), 512'd1);
        check("perr_flag", 512'(bus_if.pkt_par_err), 512'd1);
        idle(1'b1, 1);
        step(1'b1, 1'b0, 128'hdead_0003, 8'h00, 1'b0);
        check("clean_par", 512'(bus_if.pkt_par_err), 512'd0);
        idle(1'b1, 1);

        // Overflow: third header-only packet with a full buffer and no pop.
        step(1'b1, 1'b0, 128'hb1, 8'h00, 1'b0);
        step(1'b1, 1'b0, 128'hb2, 8'h00, 1'b0);
        step(1'b1, 1'b0, 128'hb3, 8'h00, 1'b0);
        check("ovf_flag", 512'(bus_if.ovf_err), 512'd1);
        check("ovf_drop", 512'(bus_if.drop_cnt), 512'd1);
        check("ovf_head", 512'(bus_if.pkt_hdr), 512'h b1);
        idle(1'b1, 2);
        check("ovf_drained", 512'(bus_if.pkt_vld), 512'd0);

        // Same pattern, but the pop on the third completion frees the slot.
        step(1'b1, 1'b0, 128'hc1, 8'h00, 1'b0);
        step(1'b1, 1'b0, 128'hc2, 8'h00, 1'b0);
        step(1'b1, 1'b0, 128'hc3, 8'h00, 1'b1);
        check("full_pop_drop", 512'(bus_if.drop_cnt), 512'd1);
        check("full_pop_head", 512'(bus_if.pkt_hdr), 512'h c2);
        idle(1'b1, 1);
        check("full_pop_next", 512'(bus_if.pkt_hdr), 512'h c3);
        idle(1'b1, 1);

        // Header arriving at beat 1 aborts the packet and starts a new one.
        step(1'b1, 1'b1, 128'hd0, 8'h00, 1'b0);
        beat(BT0, 8'h00, 1'b0);
        step(1'b1, 1'b0, 128'he0, 8'h00, 1'b0);
        check("abort_proto", 512'(bus_if.proto_err), 512'd1);
        check("abort_drop", 512'(bus_if.drop_cnt), 512'd2);
        check("abort_head", 512'(bus_if.pkt_hdr), 512'h e0);
        check("abort_has", 512'(bus_if.pkt_has_data), 512'd0);
        idle(1'b1, 1);

        // Back-to-back completions with a pop each cycle keep pkt_vld high.
        step(1'b1, 1'b0, 128'hf1, 8'h00, 1'b1);
        step(1'b1, 1'b0, 128'hf2, 8'h00, 1'b1);
        check("b2b_head", 512'(bus_if.pkt_hdr), 512'h f2);
        step(1'b1, 1'b0, 128'hf3, 8'h00, 1'b1);
        check("b2b_vld", 512'(bus_if.pkt_vld), 512'd1);
        idle(1'b1, 1);

        // Reset mid-payload with one packet buffered.
        step(1'b1, 1'b0, 128'h61, 8'h00, 1'b0);
        step(1'b1, 1'b1, 128'h62, 8'h00, 1'b0);
        beat(BT0, 8'h00, 1'b0);
        beat(BT1, 8'h00, 1'b0);
        rst = 1'b1;
        beat(BT2, 8'h00, 1'b0);
        check_zero_outputs("midrst");
        rst = 1'b0;
        step(1'b1, 1'b0, 128'h70, 8'h00, 1'b0);
        check("postrst_vld", 512'(bus_if.pkt_vld), 512'd1);
        check("postrst_hdr", 512'(bus_if.pkt_hdr), 512'h70);
        check("postrst_drop", 512'(bus_if.drop_cnt), 512'd0);
        idle(1'b1, 3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
